// File: rtl/reg_pkg.sv
// Shared constants, requester encoding and register-index decode for the
// register bank and its write-port scheduler.
package reg_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NREGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: with both requests up, the requester that
// was not granted last wins. The pointer moves only when advance is high.
module rr_arbiter2
  import reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_e ptr_reg;
  req_e ptr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= REQ_ALU;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  always_comb begin
    gnt      = req;
    ptr_next = ptr_reg;
    if (req == 2'b11) begin
      gnt = (ptr_reg == REQ_ALU) ? 2'b01 : 2'b10;
    end
    // Priority passes to whichever side did not win this transfer.
    if (advance) begin
      ptr_next = gnt[REQ_ALU] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/reg_write_sched.sv
// Write-port scheduler for the register bank: arbitrates ALU and memory
// writebacks onto one registered write path and tracks pending producers.
module reg_write_sched
  import reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [NREGS-1:0]  rf_write,
  output logic [DATA_W-1:0] rf_data,
  output logic [NREGS-1:0]  busy
);

  logic [1:0]        gnt;
  logic              accept;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  logic [NREGS-1:0]  rf_write_reg, rf_write_next;
  logic [DATA_W-1:0] rf_data_reg, rf_data_next;
  logic [NREGS-1:0]  busy_reg, busy_next;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({mem_valid, alu_valid}),
    .advance (accept),
    .gnt     (gnt)
  );

  assign alu_ready = gnt[REQ_ALU] & ~reset;
  assign mem_ready = gnt[REQ_MEM] & ~reset;
  assign accept    = alu_ready | mem_ready;

  assign sel_rd   = alu_ready ? alu_rd   : mem_rd;
  assign sel_data = alu_ready ? alu_data : mem_data;

  always_comb begin
    rf_write_next = '0;
    rf_data_next  = rf_data_reg;
    // A write to register 0 is consumed but never reaches the bank.
    if (accept && (sel_rd != '0)) begin
      rf_write_next = onehot(sel_rd);
      rf_data_next  = sel_data;
    end
  end

  always_comb begin
    busy_next = busy_reg & ~rf_write_reg;
    // Applied after the clear so a fresh producer keeps the bit set.
    if (issue_valid && (issue_rd != '0)) begin
      busy_next = busy_next | onehot(issue_rd);
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_reg <= '0;
      rf_data_reg  <= '0;
      busy_reg     <= '0;
    end else begin
      rf_write_reg <= rf_write_next;
      rf_data_reg  <= rf_data_next;
      busy_reg     <= busy_next;
    end
  end

  assign rf_write = rf_write_reg;
  assign rf_data  = rf_data_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_reg_write_sched.sv
// Randomized and directed bench for reg_write_sched against a behavioural
// model of arbitration, the registered write path and the busy scoreboard.
module tb_reg_write_sched;
  import reg_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid, mem_valid, issue_valid;
  logic              alu_ready, mem_ready;
  logic [ADDR_W-1:0] alu_rd, mem_rd, issue_rd;
  logic [DATA_W-1:0] alu_data, mem_data;
  logic [NREGS-1:0]  rf_write, busy;
  logic [DATA_W-1:0] rf_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state: who won last, and the expected registered outputs.
  int                last_gnt;
  logic [NREGS-1:0]  m_write, m_busy;
  logic [DATA_W-1:0] m_data;

  always #5 clk = ~clk;

  reg_write_sched dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rf_write   (rf_write),
    .rf_data    (rf_data),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                      input logic iv, input logic [4:0] ird,
                      output logic ga, output logic gm);
    logic [4:0]  rd;
    logic [31:0] d;
    @(negedge clk);
    reset = rst; alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    issue_valid = iv; issue_rd = ird;
    #1;
    if (rst) begin
      ga = 1'b0; gm = 1'b0;
    end else if (av && mv) begin
      ga = (last_gnt != 0); gm = ~ga;
    end else begin
      ga = av; gm = mv;
    end
    check_val("alu_ready", {31'd0, alu_ready}, {31'd0, ga});
    check_val("mem_ready", {31'd0, mem_ready}, {31'd0, gm});
    @(posedge clk);
    if (rst) begin
      last_gnt = 1; m_write = '0; m_data = '0; m_busy = '0;
    end else begin
      m_busy = m_busy & ~m_write;
      if (iv && ird != 0) m_busy[ird] = 1'b1;
      m_write = '0;
      if (ga || gm) begin
        rd = ga ? ard : mrd;
        d  = ga ? adat : mdat;
        last_gnt = ga ? 0 : 1;
        if (rd != 0) begin
          m_write = 32'd1 << rd;
          m_data  = d;
        end
      end
    end
    #1;
    check_val("rf_write", rf_write, m_write);
    check_val("rf_data", rf_data, m_data);
    check_val("busy", busy, m_busy);
    $display("t=%0t rst=%b alu=%b/%0d mem=%b/%0d iss=%b/%0d gnt=%b%b wr=%h data=%h busy=%h",
             $time, rst, av, ard, mv, mrd, iv, ird, gm, ga, rf_write, rf_data, busy);
  endtask

  initial begin
    logic        ga, gm;
    logic        a_pend, m_pend;
    logic [4:0]  a_rd, m_rd;
    logic [31:0] a_dat, m_dat;
    reset = 1'b1; alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = 0; mem_rd = 0; issue_rd = 0; alu_data = 0; mem_data = 0;
    last_gnt = 1; m_write = '0; m_data = '0; m_busy = '0;

    // Reset, then single ALU write to r5.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

    // Both streaming from reset: ALU, MEM, ALU, MEM.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, 32'h1111_0000 + i, 1, 2, 32'h2222_0000 + i, 0, 0, ga, gm);

    // Issue r7, ALU write three cycles later, then re-issue on the clearing edge.
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    step(0, 1, 7, 32'h0000_0777, 0, 0, 0, 0, 0, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    step(0, 1, 7, 32'h0000_0778, 0, 0, 0, 0, 0, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

    // MEM write to r0 and issue of r0.
    step(0, 0, 0, 0, 1, 0, 32'hCAFE_F00D, 1, 0, ga, gm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

    // Accept a write, then reset on the next edge; ALU first afterwards.
    step(0, 0, 0, 0, 1, 9, 32'h9999_9999, 1, 12, ga, gm);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
    step(0, 1, 3, 32'h3333_3333, 1, 4, 32'h4444_4444, 0, 0, ga, gm);

    // Random traffic; requesters hold valid/rd/data until accepted.
    a_pend = 0; m_pend = 0; a_rd = 0; m_rd = 0; a_dat = 0; m_dat = 0;
    for (int n = 0; n < 400; n++) begin
      logic rst;
      logic iv;
      logic [4:0] ird;
      if (!a_pend && $urandom_range(0, 2) != 0) begin
        a_pend = 1; a_rd = 5'($urandom_range(0, 31)); a_dat = $urandom;
      end
      if (!m_pend && $urandom_range(0, 2) != 0) begin
        m_pend = 1; m_rd = 5'($urandom_range(0, 31)); m_dat = $urandom;
      end
      rst = ($urandom_range(0, 59) == 0);
      iv  = ($urandom_range(0, 1) == 1);
      ird = 5'($urandom_range(0, 31));
      step(rst, a_pend, a_rd, a_dat, m_pend, m_rd, m_dat, iv, ird, ga, gm);
      if (ga) a_pend = 0;
      if (gm) m_pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_write_sched.md
# reg_write_sched

Write-port scheduler for the 32-entry register bank built from 32-bit `Register` instances. It arbitrates the ALU and memory writeback requesters onto the bank's single write path and drives one-hot per-register `write` enables plus shared write data. It also keeps a busy scoreboard of registers with an outstanding producer, which the decode stage reads for hazard stalls.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width
- NREGS, 32, number of registers (2**ADDR_W)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  memory writeback request
- mem_ready  out  1  memory request accepted this cycle
- mem_rd  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  load data
- issue_valid  in  1  decode issues an instruction with a destination
- issue_rd  in  ADDR_W  destination of the issued instruction
- rf_write  out  NREGS  one-hot write enables, one per `Register` instance
- rf_data  out  DATA_W  shared write data to all instances
- busy  out  NREGS  scoreboard; bit i high means a write to register i is pending

## Operation
- Handshake: a transfer occurs when valid and ready are both high at the rising edge. Ready is combinational from both valids and the round-robin pointer. Valid must hold, with stable rd and data, until accepted.
- Arbitration:
  - One valid requester: it is granted.
  - Both valid: grant the requester not granted last.
  - The pointer updates only on an accepted transfer. Its reset value gives the ALU priority.
  - At most one ready is high per cycle.
- Accepted transfer, rd ≠ 0: rf_write is loaded with the one-hot of rd and rf_data with the data, both registered. With no transfer, rf_write loads 0 and rf_data holds.
- Accepted transfer, rd = 0: the request is consumed but rf_write loads 0. Register 0 is never written.
- Scoreboard:
  - busy[issue_rd] is set on an edge with issue_valid and issue_rd ≠ 0.
  - busy[rd] is cleared on the edge where the registered rf_write for rd is high. This is the same edge at which the `Register` captures.
  - Set and clear of the same bit on the same edge: set wins, because a newer producer is outstanding.
  - busy[0] is constant 0.
- Same rd from both requesters in one cycle: serialized in arbitration order. The later grant is the final value.
- Reset: rf_write = 0, rf_data = 0, busy = 0, pointer = ALU-first. A registered write pending at reset is discarded and its register is not written. ready outputs are 0 while reset is high.

## Timing
- Acceptance at edge N → rf_write/rf_data valid during cycle N..N+1 → `Register` q updates at edge N+1 → busy bit clears at edge N+1.
- Throughput: one write per cycle sustained. With both requesters streaming, each gets every other cycle.
- No combinational path from issue_* to any output. busy is a pure register output.
- Ready is combinational from the valids. There is no combinational loop provided requesters do not derive valid from ready.

## Structure
- Shared package reg_pkg holds:
  - DATA_W, ADDR_W and NREGS constants.
  - A requester enum: REQ_ALU = 0, REQ_MEM = 1.
  - A one-hot decode function from ADDR_W to NREGS, reused by the register-bank top.
- One sub-module, rr_arbiter2: a two-input round-robin arbiter with a pointer register, inputs req[1:0] and advance, output gnt[1:0]. The scoreboard and write register stay in reg_write_sched.

## Test plan
- Reset then alu_valid, rd = 5, data = 0xDEADBEEF → alu_ready = 1 same cycle. Next cycle rf_write = 0x00000020, rf_data = 0xDEADBEEF. Register 5 q = 0xDEADBEEF after the following edge.
- Both valid for 4 cycles, ALU rd = 1, MEM rd = 2 → grants ALU, MEM, ALU, MEM. rf_write sequence 0x2, 0x4, 0x2, 0x4.
- issue_valid rd = 7, then an ALU write to 7 three cycles later → busy[7] is 1 from the issue edge until the edge after acceptance, then 0.
- Same-edge new issue of rd = 7 while the rf_write for 7 is high → busy[7] remains 1.
- MEM write with rd = 0 → mem_ready = 1, rf_write stays 0, busy[0] stays 0. Issue of rd = 0 leaves busy = 0.
- Accept a write, assert reset on the next edge → rf_write = 0, register unchanged, busy = 0. ALU is granted first when both are valid after reset.
